launch_command_scheduler: RTL and testbench



---
 rtl/launch_command_scheduler.sv | 146 ++++++++++++++
 tb/tb_launch_command_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/launch_command_scheduler.sv
// Queues parsed shot commands and releases them as a cooldown-spaced salvo.
// Build with M4G_SHOT_COUNTER_EN defined to count transfers on shots_fired.
module launch_command_scheduler #(
    parameter int DEPTH           = 8,
    parameter int CNT_W           = 4,
    parameter int COOLDOWN_CYCLES = 1000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    input  logic [31:0]      cmd_velocity,
    input  logic [31:0]      cmd_angle,
    input  logic             cmd_queue,
    input  logic             cmd_fire,
    input  logic             cmd_clear,
    output logic             launch_valid,
    output logic [31:0]      launch_velocity,
    output logic [31:0]      launch_angle,
    input  logic             launch_ready,
    output logic [CNT_W-1:0] queue_count,
    output logic             salvo_active,
    output logic             cooldown_active,
    output logic             overflow,
    output logic [15:0]      shots_fired
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(COOLDOWN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PRESENT, COOLDOWN} state_e;

    state_e           state_q;
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      vel_mem [DEPTH];
    logic [31:0]      ang_mem [DEPTH];
    logic [CW-1:0]    cd_q;
    logic             valid_q, salvo_q, cool_q, ovf_q;
    logic [31:0]      vel_q, ang_q;

    logic do_clear, do_push, do_fire, xfer, push_ok, fire_ok;

    assign do_clear = cmd_valid & cmd_clear;
    assign do_push  = cmd_valid & ~cmd_clear & cmd_queue;
    assign do_fire  = cmd_valid & ~cmd_clear & cmd_fire;
    // A clear in the same cycle as ready cancels the handshake.
    assign xfer     = (state_q == PRESENT) & valid_q & launch_ready & ~do_clear;
    assign push_ok  = do_push & ((count_q < CNT_W'(DEPTH)) | xfer);

    always_comb begin
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(xfer);
    end

    assign fire_ok = do_fire & (count_d != '0);

    always_ff @(posedge clock) begin
        if (push_ok) begin
            vel_mem[wr_ptr_q] <= cmd_velocity;
            ang_mem[wr_ptr_q] <= cmd_angle;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || do_clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (xfer)    rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            if (do_push && !push_ok) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || do_clear) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            vel_q   <= reset_n ? vel_q : '0;
            ang_q   <= reset_n ? ang_q : '0;
            salvo_q <= 1'b0;
            cool_q  <= 1'b0;
            cd_q    <= '0;
        end else begin
            if (fire_ok) salvo_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (salvo_q && count_q != '0) begin
                        vel_q   <= vel_mem[rd_ptr_q];
                        ang_q   <= ang_mem[rd_ptr_q];
                        valid_q <= 1'b1;
                        state_q <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (launch_ready) begin
                        valid_q <= 1'b0;
                        cool_q  <= 1'b1;
                        cd_q    <= CW'(COOLDOWN_CYCLES);
                        state_q <= COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    cd_q <= cd_q - CW'(1);
                    if (cd_q == CW'(1)) begin
                        cool_q <= 1'b0;
                        if (salvo_q && count_q != '0) begin
                            vel_q   <= vel_mem[rd_ptr_q];
                            ang_q   <= ang_mem[rd_ptr_q];
                            valid_q <= 1'b1;
                            state_q <= PRESENT;
                        end else begin
                            state_q <= IDLE;
                            if (count_q == '0 && !fire_ok) salvo_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef M4G_SHOT_COUNTER_EN
    logic [15:0] shots_q;

    always_ff @(posedge clock) begin
        if (!reset_n)  shots_q <= '0;
        else if (xfer) shots_q <= shots_q + 16'd1;
    end

    assign shots_fired = shots_q;
`else
    assign shots_fired = '0;
`endif

    assign launch_valid    = valid_q;
    assign launch_velocity = vel_q;
    assign launch_angle    = ang_q;
    assign queue_count     = count_q;
    assign salvo_active    = salvo_q;
    assign cooldown_active = cool_q;
    assign overflow        = ovf_q;

endmodule

// File: tb/tb_launch_command_scheduler.sv
// Scoreboard bench for launch_command_scheduler with a short cooldown.
module tb_launch_command_scheduler;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int CD    = 4;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             cmd_valid, cmd_queue, cmd_fire, cmd_clear;
    logic [31:0]      cmd_velocity, cmd_angle;
    logic             launch_valid, launch_ready;
    logic [31:0]      launch_velocity, launch_angle;
    logic [CNT_W-1:0] queue_count;
    logic             salvo_active, cooldown_active, overflow;
    logic [15:0]      shots_fired;

    launch_command_scheduler #(
        .DEPTH(DEPTH), .CNT_W(CNT_W), .COOLDOWN_CYCLES(CD)
    ) dut (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid),
        .cmd_velocity(cmd_velocity), .cmd_angle(cmd_angle),
        .cmd_queue(cmd_queue), .cmd_fire(cmd_fire), .cmd_clear(cmd_clear),
        .launch_valid(launch_valid), .launch_velocity(launch_velocity),
        .launch_angle(launch_angle), .launch_ready(launch_ready),
        .queue_count(queue_count), .salvo_active(salvo_active),
        .cooldown_active(cooldown_active), .overflow(overflow),
        .shots_fired(shots_fired)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] v;
        logic [31:0] a;
    } shot_t;

    shot_t sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    xfer_cyc = 0;
    int    n_xfer = 0;
    int    exp_shots = 0;
    bit    gap_armed = 0;
    bit    prev_valid = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_shots(input string name);
`ifdef M4G_SHOT_COUNTER_EN
        chk(name, 64'(shots_fired), 64'(exp_shots));
`else
        chk(name, 64'(shots_fired), 64'd0);
`endif
    endtask

    // Monitor: a transfer is committed at the next posedge.
    always @(negedge clock) begin
        shot_t e;
        if (launch_valid && !prev_valid && gap_armed) begin
            chk("cooldown_gap", 64'(cyc - xfer_cyc), 64'(CD));
            gap_armed = 0;
        end
        if (!salvo_active) gap_armed = 0;
        if (reset_n && launch_valid && launch_ready &&
            !(cmd_valid && cmd_clear)) begin
            n_xfer++;
            exp_shots++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_launch: got v=%0d a=%0d expected none",
                         launch_velocity, launch_angle);
            end else begin
                e = sb.pop_front();
                chk("launch_velocity", 64'(launch_velocity), 64'(e.v));
                chk("launch_angle", 64'(launch_angle), 64'(e.a));
            end
            gap_armed = 1;
            xfer_cyc  = cyc + 1;
        end
        prev_valid = launch_valid;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] v, input logic [31:0] a,
                         input logic q, input logic f, input logic c);
        cmd_valid    = 1'b1;
        cmd_velocity = v;
        cmd_angle    = a;
        cmd_queue    = q;
        cmd_fire     = f;
        cmd_clear    = c;
        tick();
        cmd_valid = 1'b0;
        cmd_queue = 1'b0;
        cmd_fire  = 1'b0;
        cmd_clear = 1'b0;
    endtask

    task automatic push(input logic [31:0] v, input logic [31:0] a,
                        input bit accept);
        shot_t e;
        e.v = v;
        e.a = a;
        if (accept) sb.push_back(e);
        issue(v, a, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic wait_valid(input int lim);
        int n = 0;
        while (!launch_valid && n < lim) begin
            tick();
            n++;
        end
        chk("wait_valid", 64'(launch_valid), 64'd1);
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((salvo_active || launch_valid || cooldown_active) && n < lim) begin
            tick();
            n++;
        end
        chk("wait_idle", {61'd0, salvo_active, launch_valid, cooldown_active}, 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 64'(launch_valid), 64'd0);
        chk({tag, "_vel"}, 64'(launch_velocity), 64'd0);
        chk({tag, "_ang"}, 64'(launch_angle), 64'd0);
        chk({tag, "_count"}, 64'(queue_count), 64'd0);
        chk({tag, "_salvo"}, 64'(salvo_active), 64'd0);
        chk({tag, "_cool"}, 64'(cooldown_active), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
        chk({tag, "_shots"}, 64'(shots_fired), 64'd0);
    endtask

    initial begin
        int x0;
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_queue = 1'b0; cmd_fire = 1'b0; cmd_clear = 1'b0;
        cmd_velocity = '0; cmd_angle = '0;
        launch_ready = 1'b0;
        tick();
        tick();
        chk_reset_vals("reset");
        reset_n = 1'b1;
        tick();

        // Basic three-shot salvo
        launch_ready = 1'b1;
        push(10, 45, 1);
        push(20, 30, 1);
        push(30, 60, 1);
        chk("t1_count", 64'(queue_count), 64'd3);
        chk("t1_valid_pre", 64'(launch_valid), 64'd0);
        issue(0, 0, 1'b0, 1'b1, 1'b0);
        chk("t1_salvo", 64'(salvo_active), 64'd1);
        chk("t1_valid_n", 64'(launch_valid), 64'd0);
        tick();
        chk("t1_valid_n1", 64'(launch_valid), 64'd1);
        wait_idle(100);
        chk("t1_count_end", 64'(queue_count), 64'd0);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);
        chk_shots("t1_shots");

        // Fire on empty queue, then queue+fire together
        issue(0, 0, 1'b0, 1'b1, 1'b0);
        chk("t2_salvo_empty", 64'(salvo_active), 64'd0);
        repeat (3) tick();
        chk("t2_valid_empty", 64'(launch_valid), 64'd0);
        sb.push_back('{v: 32'd5, a: 32'd15});
        issue(5, 15, 1'b1, 1'b1, 1'b0);
        chk("t2_salvo", 64'(salvo_active), 64'd1);
        chk("t2_valid_n", 64'(launch_valid), 64'd0);
        tick();
        chk("t2_valid_n1", 64'(launch_valid), 64'd1);
        chk("t2_vel", 64'(launch_velocity), 64'd5);
        chk("t2_ang", 64'(launch_angle), 64'd15);
        wait_idle(100);

        // Overflow, then push while full alongside a transfer
        launch_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++)
            push(32'(100 + i), 32'(200 + i), i < DEPTH);
        chk("t3_count_full", 64'(queue_count), 64'd8);
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_salvo_idle", 64'(salvo_active), 64'd0);
        launch_ready = 1'b1;
        issue(0, 0, 1'b0, 1'b1, 1'b0);
        wait_valid(10);
        chk("t3_count_pre", 64'(queue_count), 64'd8);
        push(500, 600, 1);
        chk("t3_count_swap", 64'(queue_count), 64'd8);
        chk("t3_ovf_keep", 64'(overflow), 64'd1);
        wait_idle(200);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Back-pressure: held data stays stable
        launch_ready = 1'b0;
        push(7, 8, 1);
        issue(0, 0, 1'b0, 1'b1, 1'b0);
        wait_valid(10);
        x0 = n_xfer;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_valid_hold", 64'(launch_valid), 64'd1);
            chk("t4_vel_hold", 64'(launch_velocity), 64'd7);
            chk("t4_ang_hold", 64'(launch_angle), 64'd8);
        end
        launch_ready = 1'b1;
        wait_idle(100);
        chk("t4_one_xfer", 64'(n_xfer - x0), 64'd1);
        chk_shots("t4_shots");

        // Clear while presenting
        launch_ready = 1'b0;
        push(11, 12, 1);
        push(13, 14, 1);
        push(15, 16, 1);
        issue(0, 0, 1'b0, 1'b1, 1'b0);
        wait_valid(10);
        chk("t5_count_pre", 64'(queue_count), 64'd3);
        chk("t5_ovf_pre", 64'(overflow), 64'd1);
        x0 = n_xfer;
        launch_ready = 1'b1;
        issue(0, 0, 1'b1, 1'b1, 1'b1);
        sb.delete();
        chk("t5_valid", 64'(launch_valid), 64'd0);
        chk("t5_count", 64'(queue_count), 64'd0);
        chk("t5_ovf", 64'(overflow), 64'd0);
        chk("t5_salvo", 64'(salvo_active), 64'd0);
        chk("t5_cool", 64'(cooldown_active), 64'd0);
        repeat (3) tick();
        chk("t5_valid_after", 64'(launch_valid), 64'd0);
        chk("t5_no_xfer", 64'(n_xfer - x0), 64'd0);
        chk_shots("t5_shots");

        // Reset during cooldown
        push(21, 22, 1);
        push(23, 24, 1);
        issue(0, 0, 1'b0, 1'b1, 1'b0);
        x0 = 0;
        while (!cooldown_active && x0 < 20) begin
            tick();
            x0++;
        end
        chk("t6_in_cool", 64'(cooldown_active), 64'd1);
        reset_n = 1'b0;
        tick();
        chk_reset_vals("t6_reset");
        sb.delete();
        exp_shots = 0;
        gap_armed = 0;
        reset_n = 1'b1;
        tick();

        // Post-reset sanity
        sb.push_back('{v: 32'd31, a: 32'd32});
        issue(31, 32, 1'b1, 1'b1, 1'b0);
        wait_idle(100);
        chk("t7_sb_empty", 64'(sb.size()), 64'd0);
        chk_shots("t7_shots");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
